// File: rtl/shift_sched_if.sv
// shift_sched_if: command, response and shifter-side signals of the shift scheduler.
// The scheduler uses the slave view; the surrounding system (requesters, consumer
// and the shared funnel shifter) uses the master view.
interface shift_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_data;
    logic [2:0] req0_kind;
    logic [3:0] req0_count;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_data;
    logic [2:0] req1_kind;
    logic [3:0] req1_count;

    logic [7:0] sh_i;
    logic [2:0] sh_kind;
    logic [3:0] sh_count;
    logic [7:0] sh_o;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport slave (
        input  req0_valid, req0_data, req0_kind, req0_count,
        input  req1_valid, req1_data, req1_kind, req1_count,
        input  sh_o, rsp_ready,
        output req0_ready, req1_ready,
        output sh_i, sh_kind, sh_count,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req0_valid, req0_data, req0_kind, req0_count,
        output req1_valid, req1_data, req1_kind, req1_count,
        output sh_o, rsp_ready,
        input  req0_ready, req1_ready,
        input  sh_i, sh_kind, sh_count,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler sharing one 8-bit funnel shifter between two
// requesters. Counts above MAX_STEP are split into several registered passes and the
// result is returned on one response channel tagged with the requester id.
module shift_sched #(
    parameter int unsigned MAX_STEP = 7
) (
    input  logic         clk,
    input  logic         rst,
    shift_sched_if.slave bus
);
    localparam logic [3:0] STEP = 4'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] remaining_q, remaining_d;
    logic [7:0] sh_i_q, sh_i_d;
    logic [2:0] sh_kind_q, sh_kind_d;
    logic [3:0] sh_count_q, sh_count_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    logic       grant0;
    logic       grant1;
    logic       grant_any;
    logic [7:0] sel_data;
    logic [2:0] sel_kind;
    logic [3:0] sel_count;
    logic [3:0] rem_next;

    // Largest count the shifter may see in a single pass.
    function automatic logic [3:0] clip(input logic [3:0] c);
        return (c > STEP) ? STEP : c;
    endfunction

    // Round-robin grant; ready is only ever offered while idle and out of reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        grant_any = grant0 | grant1;
        sel_data  = grant1 ? bus.req1_data  : bus.req0_data;
        sel_kind  = grant1 ? bus.req1_kind  : bus.req0_kind;
        sel_count = grant1 ? bus.req1_count : bus.req0_count;
    end

    // Next-state and next-output logic; the shifter outputs only move at a grant or between passes.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        sh_i_d      = sh_i_q;
        sh_kind_d   = sh_kind_q;
        sh_count_d  = sh_count_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rem_next    = remaining_q - sh_count_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    ptr_d    = ~grant1;
                    rsp_id_d = grant1;
                    if (sel_kind[2:1] == 2'b11) begin
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = sel_data;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        rsp_err_d   = 1'b0;
                        sh_i_d      = sel_data;
                        sh_kind_d   = sel_kind;
                        sh_count_d  = clip(sel_count);
                        remaining_d = sel_count;
                        state_d     = SHIFT;
                    end
                end
            end
            SHIFT: begin
                remaining_d = rem_next;
                if (rem_next == 4'd0) begin
                    rsp_data_d  = bus.sh_o;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    sh_i_d     = bus.sh_o;
                    sh_count_d = clip(rem_next);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            remaining_q <= 4'd0;
            sh_i_q      <= 8'd0;
            sh_kind_q   <= 3'd0;
            sh_count_q  <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            sh_i_q      <= sh_i_d;
            sh_kind_q   <= sh_kind_d;
            sh_count_q  <= sh_count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.sh_i       = sh_i_q;
    assign bus.sh_kind    = sh_kind_q;
    assign bus.sh_count   = sh_count_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule
